// File: rtl/system_cpu_mul_pkg.sv
// system_cpu_mul_pkg: shared op encodings, FSM states and pass types for the multiply sequencer
package system_cpu_mul_pkg;
  localparam int DW = 32;
  typedef logic [1:0] op_t;
  localparam op_t OP_MUL    = 2'b00;
  localparam op_t OP_MULXUU = 2'b01;
  localparam op_t OP_MULXSU = 2'b10;
  localparam op_t OP_MULXSS = 2'b11;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ISSUE   = 3'd1;
  localparam state_t S_DRAIN   = 3'd2;
  localparam state_t S_SIGNFIX = 3'd3;
  localparam state_t S_DONE    = 3'd4;
  typedef logic [1:0] pass_t;
  // lo*lo lands at bit 0, the two cross terms at bit 16, hi*hi at bit 32
  function automatic logic [5:0] pass_shift(input pass_t p);
    return (p == 2'd3) ? 6'd32 : (p == 2'd0) ? 6'd0 : 6'd16;
  endfunction
endpackage

// File: rtl/system_cpu_mul_seq_acc.sv
// system_cpu_mul_seq_acc: product accumulator with shift-add and signed high-word correction
// (SYSTEM_CPU_MUL_SEQ_MULX_EN selects the 64-bit four-pass datapath; otherwise a plain capture)
module system_cpu_mul_seq_acc
  import system_cpu_mul_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          cap,
  input  pass_t         pass,
  input  logic [DW-1:0] product,
  input  logic          fix,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sgn_a,
  input  logic          sgn_b,
  output logic [2*DW-1:0] acc
);
`ifdef SYSTEM_CPU_MUL_SEQ_MULX_EN
  logic [DW-1:0] corr;
  // unsigned product minus the two's-complement weight of each negative signed operand
  assign corr = ((sgn_a && a[DW-1]) ? b : '0) + ((sgn_b && b[DW-1]) ? a : '0);
  always_ff @(posedge clk) begin
    if (reset || clr) acc <= '0;
    else if (cap) acc <= acc + ({{DW{1'b0}}, product} << pass_shift(pass));
    else if (fix) acc[2*DW-1:DW] <= acc[2*DW-1:DW] - corr;
  end
`else
  logic unused;
  assign unused = ^{pass, fix, a, b, sgn_a, sgn_b};
  always_ff @(posedge clk) begin
    if (reset || clr) acc <= '0;
    else if (cap) acc <= {{DW{1'b0}}, product};
  end
`endif
endmodule

// File: rtl/system_cpu_mul_seq.sv
// system_cpu_mul_seq: multi-pass sequencer feeding a low-32 multiplier cell for MUL/MULX* ops
// (define SYSTEM_CPU_MUL_SEQ_MULX_EN to enable MULXUU/MULXSU/MULXSS; otherwise they return illegal)
module system_cpu_mul_seq
  import system_cpu_mul_pkg::*;
#(
  parameter int CELL_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_src1,
  input  logic [DW-1:0] in_src2,
  output logic [DW-1:0] mul_src1,
  output logic [DW-1:0] mul_src2,
  input  logic [DW-1:0] mul_cell_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_illegal
);
  state_t state;
  op_t op_q;
  logic [DW-1:0] a_q, b_q;
  pass_t pass_q;
  logic ill_q;
  logic [CELL_LATENCY-1:0] tag_v, tag_last;
  pass_t tag_pass [CELL_LATENCY];
  logic mulx, ill_in, issue, last_pass, cap, cap_last;
  logic [2*DW-1:0] acc;
  assign in_ready = state == S_IDLE;
  assign issue = state == S_ISSUE;
`ifdef SYSTEM_CPU_MUL_SEQ_MULX_EN
  assign mulx = op_q != OP_MUL;
  assign ill_in = 1'b0;
  always_comb begin
    mul_src1 = !issue ? '0 : mulx ? {16'b0, pass_q[0] ? a_q[DW-1:DW/2] : a_q[DW/2-1:0]} : a_q;
    mul_src2 = !issue ? '0 : mulx ? {16'b0, pass_q[1] ? b_q[DW-1:DW/2] : b_q[DW/2-1:0]} : b_q;
  end
`else
  assign mulx = 1'b0;
  assign ill_in = in_op != OP_MUL;
  always_comb begin
    mul_src1 = issue ? a_q : '0;
    mul_src2 = issue ? b_q : '0;
  end
`endif
  assign last_pass = pass_q == (mulx ? 2'd3 : 2'd0);
  assign cap = tag_v[CELL_LATENCY-1];
  assign cap_last = cap && tag_last[CELL_LATENCY-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q <= OP_MUL;
      a_q <= '0;
      b_q <= '0;
      pass_q <= '0;
      ill_q <= 1'b0;
      tag_v <= '0;
      tag_last <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_last[0] <= issue && last_pass;
      for (int i = 1; i < CELL_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      case (state)
        S_IDLE: if (in_valid) begin
          op_q <= in_op;
          a_q <= in_src1;
          b_q <= in_src2;
          pass_q <= '0;
          ill_q <= ill_in;
          state <= ill_in ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          pass_q <= pass_q + 2'd1;
          if (last_pass) state <= S_DRAIN;
        end
        S_DRAIN: if (cap_last) state <= mulx ? S_SIGNFIX : S_DONE;
        S_SIGNFIX: state <= S_DONE;
        S_DONE: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  // pass index travels alongside the cell pipeline so each capture knows its shift
  always_ff @(posedge clk) begin
    tag_pass[0] <= pass_q;
    for (int i = 1; i < CELL_LATENCY; i++) tag_pass[i] <= tag_pass[i-1];
  end
  system_cpu_mul_seq_acc u_acc (
    .clk(clk),
    .reset(reset),
    .clr(in_valid && in_ready),
    .cap(cap),
    .pass(tag_pass[CELL_LATENCY-1]),
    .product(mul_cell_result),
    .fix(state == S_SIGNFIX),
    .a(a_q),
    .b(b_q),
    .sgn_a(op_q[1]),
    .sgn_b(&op_q),
    .acc(acc)
  );
  assign res_valid = state == S_DONE;
  assign res_illegal = res_valid && ill_q;
  assign res_data = (res_valid && !ill_q) ? (mulx ? acc[2*DW-1:DW] : acc[DW-1:0]) : '0;
endmodule

// File: tb/tb_system_cpu_mul_seq.sv
// tb_system_cpu_mul_seq: directed table-driven checks plus backpressure and mid-operation reset sequences
module tb_system_cpu_mul_seq;
  import system_cpu_mul_pkg::*;
`ifdef SYSTEM_CPU_MUL_SEQ_MULX_EN
  localparam bit MX = 1'b1;
`else
  localparam bit MX = 1'b0;
`endif
  logic clk = 0, reset = 1, in_valid = 0, res_ready = 0;
  logic [1:0] in_op = 0;
  logic [31:0] in_src1 = 0, in_src2 = 0, cell_q = 0;
  logic in_ready, res_valid, res_illegal;
  logic [31:0] mul_src1, mul_src2, res_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cell_q <= mul_src1 * mul_src2;
  system_cpu_mul_seq #(.CELL_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_cell_result(cell_q), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_illegal(res_illegal)
  );
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b, d;
    logic ill;
    int lat, passes;
  } vec_t;
  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, b, d, input int p);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    if (op == OP_MUL || MX) begin
      v.d = d; v.ill = 1'b0; v.lat = (op == OP_MUL) ? 3 : 7; v.passes = p;
    end else begin
      v.d = 0; v.ill = 1'b1; v.lat = 1; v.passes = 0;
    end
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string n);
    int t, p, sb;
    t = 0; p = 0; sb = 0;
    @(negedge clk);
    chk({n, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1; in_op = v.op; in_src1 = v.a; in_src2 = v.b;
    do begin
      @(negedge clk);
      in_valid = 0;
      t++;
      if (mul_src1 != 0 || mul_src2 != 0) begin
        p++;
        if (v.op == OP_MUL ? (mul_src1 !== v.a || mul_src2 !== v.b)
                           : (mul_src1[31:16] != 0 || mul_src2[31:16] != 0)) sb++;
      end
    end while (!res_valid && t < 20);
    chk({n, "_latency"}, 32'(t), 32'(v.lat));
    chk({n, "_data"}, res_data, v.d);
    chk({n, "_illegal"}, 32'(res_illegal), 32'(v.ill));
    chk({n, "_passes"}, 32'(p), 32'(v.passes));
    chk({n, "_src_shape"}, 32'(sb), 32'd0);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk({n, "_ready_after"}, 32'(in_ready), 32'd1);
    chk({n, "_valid_after"}, 32'(res_valid), 32'd0);
  endtask
  vec_t vt[16];
  initial begin
    int t;
    vt[0]  = mk(OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
    vt[1]  = mk(OP_MUL,    32'd3,         32'd5,         32'd15,        1);
    vt[2]  = mk(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    vt[3]  = mk(OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1);
    vt[4]  = mk(OP_MUL,    32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1);
    vt[5]  = mk(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    vt[6]  = mk(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    vt[7]  = mk(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4);
    vt[8]  = mk(OP_MULXSS, 32'd7,         32'd9,         32'h0000_0000, 3);
    vt[9]  = mk(OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    vt[10] = mk(OP_MULXSU, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 4);
    vt[11] = mk(OP_MULXUU, 32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 4);
    vt[12] = mk(OP_MULXSS, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 4);
    vt[13] = mk(OP_MULXUU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 4);
    vt[14] = mk(OP_MULXSU, 32'd5,         32'hFFFF_FFFF, 32'h0000_0004, 4);
    vt[15] = mk(OP_MULXSS, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_illegal", 32'(res_illegal), 32'd0);
    chk("rst_mul_src1", mul_src1, 32'd0);
    chk("rst_mul_src2", mul_src2, 32'd0);
    reset = 0;
    for (int i = 0; i < 16; i++) run(vt[i], $sformatf("vec%0d", i));
    // backpressure: result held while consumer stalls, new requests ignored
    @(negedge clk);
    in_valid = 1; in_op = OP_MUL; in_src1 = 32'd3; in_src2 = 32'd5;
    t = 0;
    do begin
      @(negedge clk);
      in_valid = 0;
      t++;
    end while (!res_valid && t < 20);
    chk("bp_latency", 32'(t), 32'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_op = OP_MUL; in_src1 = 32'd7; in_src2 = 32'd11;
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(res_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", i), res_data, 32'd15);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 0;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    repeat (4) @(negedge clk);
    chk("bp_no_ghost_valid", 32'(res_valid), 32'd0);
    chk("bp_no_ghost_src", mul_src1 | mul_src2, 32'd0);
    // reset while a pass is in flight (pass2 when MULX is built, the single MUL pass otherwise)
    @(negedge clk);
    in_valid = 1; in_op = MX ? OP_MULXUU : OP_MUL; in_src1 = 32'hFFFF_FFFF; in_src2 = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 0;
    repeat (MX ? 2 : 0) @(negedge clk);
    chk("rm_inflight_src1", mul_src1, MX ? 32'h0000_FFFF : 32'hFFFF_FFFF);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    chk("rm_res_valid", 32'(res_valid), 32'd0);
    chk("rm_mul_src1", mul_src1, 32'd0);
    repeat (3) @(negedge clk);
    chk("rm_no_late_valid", 32'(res_valid), 32'd0);
    run(mk(OP_MUL, 32'd3, 32'd5, 32'd15, 1), "rm_post_mul");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end
endmodule
